rnd_harvester: RTL and testbench



---
 rtl/snpu_rnd_pkg.sv | 16 +
 rtl/rnd_byte_fifo.sv | 56 +++++
 rtl/rnd_harvester.sv | 178 +++++++++++++++++
 tb/tb_rnd_harvester.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snpu_rnd_pkg.sv
// Shared widths and FSM state type for the ring-oscillator random harvester.
package snpu_rnd_pkg;

  localparam int unsigned BANK_W = 5;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PAIRS  = WORD_W / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FREEZE,
    ST_EXTRACT,
    ST_RELEASE
  } hv_state_e;

endpackage

// File: rtl/rnd_byte_fifo.sv
// Small byte FIFO (power-of-2 depth); push while full is accepted only with a same-cycle pop.
module rnd_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_q];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wr_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rnd_harvester.sv
// Round-robin harvester: freeze/sample each oscillator bank, von Neumann debias,
// pack bits LSB-first into bytes, buffer in a FIFO, and flag a stuck source.
module rnd_harvester
  import snpu_rnd_pkg::*;
#(
  parameter int unsigned NBANK       = 32,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned RUN_CYC     = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STUCK_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rnd_freeze,
  output logic [BANK_W-1:0] rnd_addr,
  input  logic [WORD_W-1:0] rnd_word,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fault
);

  localparam int unsigned CNT_HI = (RUN_CYC > SETTLE_CYC) ? RUN_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W  = $clog2(((CNT_HI > PAIRS) ? CNT_HI : PAIRS) + 1);
  localparam int unsigned KW     = $clog2(PAIRS);
  localparam int unsigned ACC_W  = $clog2(BYTE_W);
  localparam int unsigned STK_W  = $clog2(STUCK_LIMIT + 1);

  hv_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BANK_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] prev_q, prev_d;
  logic [STK_W-1:0]  stuck_q, stuck_d;
  logic              fault_q, fault_d;
  logic [BYTE_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              freeze_q, freeze_d;
  logic [WORD_W-1:0] sync1_q, sync2_q;

  logic [1:0]        pair;
  logic [BYTE_W-1:0] byte_c;
  logic              push;
  logic              degen;
  logic              fifo_full;
  logic              fifo_empty;

  assign degen = (sync2_q == '0) || (sync2_q == '1) || (sync2_q == prev_q);

  // Next-state: scan FSM, extractor/accumulator and stuck-source check
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    word_d    = word_q;
    prev_d    = prev_q;
    stuck_d   = stuck_q;
    fault_d   = fault_q;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    push      = 1'b0;
    pair      = word_q[{cnt_q[KW-1:0], 1'b0} +: 2];
    byte_c    = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (en && !fifo_full) begin
          state_d = ST_FREEZE;
          cnt_d   = '0;
        end
      end
      ST_FREEZE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          word_d  = sync2_q;
          prev_d  = sync2_q;
          state_d = ST_EXTRACT;
          cnt_d   = '0;
          if (degen) begin
            if (stuck_q != STK_W'(STUCK_LIMIT)) begin
              stuck_d = stuck_q + 1'b1;
            end
            if (stuck_q >= STK_W'(STUCK_LIMIT - 1)) begin
              fault_d = 1'b1;
            end
          end else begin
            stuck_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EXTRACT: begin
        // 10 emits 1, 01 emits 0; the emitted bit equals the pair's upper bit
        if (pair[1] ^ pair[0]) begin
          byte_c[acc_cnt_q] = pair[1];
          if (acc_cnt_q == ACC_W'(BYTE_W - 1)) begin
            push      = 1'b1;
            acc_d     = '0;
            acc_cnt_d = '0;
          end else begin
            acc_d     = byte_c;
            acc_cnt_d = acc_cnt_q + 1'b1;
          end
        end
        if (cnt_q[KW-1:0] == KW'(PAIRS - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          addr_d  = (addr_q == BANK_W'(NBANK - 1)) ? '0 : addr_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(RUN_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    freeze_d = (state_d == ST_FREEZE) || (state_d == ST_EXTRACT);
  end

  // State and synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      word_q    <= '0;
      prev_q    <= '0;
      stuck_q   <= '0;
      fault_q   <= 1'b0;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      freeze_q  <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      prev_q    <= prev_d;
      stuck_q   <= stuck_d;
      fault_q   <= fault_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      freeze_q  <= freeze_d;
      sync1_q   <= rnd_word;
      sync2_q   <= sync1_q;
    end
  end

  rnd_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (byte_c),
    .pop_i     (out_ready),
    .rd_data_o (out_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rnd_freeze = freeze_q;
  assign rnd_addr   = addr_q;
  assign out_valid  = !fifo_empty;
  assign fault      = fault_q;

endmodule

// File: tb/tb_rnd_harvester.sv
// Randomized/directed bench for rnd_harvester against a harvest-level reference model.
module tb_rnd_harvester;

  localparam int SETTLE = 4;
  localparam int RUN    = 16;
  localparam int NB     = 32;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rnd_freeze;
  logic [4:0]  rnd_addr;
  logic [15:0] rnd_word;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        fault;

  rnd_harvester dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rnd_freeze (rnd_freeze),
    .rnd_addr   (rnd_addr),
    .rnd_word   (rnd_word),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fault      (fault)
  );

  int         n_chk;
  int         n_err;
  logic [7:0] exp_q[$];
  bit         bits_q[$];
  int         hcount;
  int         pop_cnt;
  logic [7:0] last_pop;
  int         m_addr;
  logic [15:0] m_prev;
  int         m_stuck;
  bit         m_fault;
  int         mode;
  int         rdy_mode;
  bit         prev_frz;
  bit         first_h;
  int         hi_len;
  int         lo_len;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    bits_q.delete();
    m_addr   = 0;
    m_prev   = 16'h0000;
    m_stuck  = 0;
    m_fault  = 1'b0;
    prev_frz = 1'b0;
    first_h  = 1'b1;
    hi_len   = 0;
    lo_len   = 0;
  endtask

  // One harvest of word w: health bookkeeping, then von Neumann bits into bytes
  task automatic model_harvest(input logic [15:0] w);
    logic [7:0] b;
    bit deg;
    deg = (w == 16'h0000) || (w == 16'hFFFF) || (w == m_prev);
    if (deg) m_stuck = (m_stuck < 8) ? m_stuck + 1 : 8;
    else     m_stuck = 0;
    if (m_stuck >= 8) m_fault = 1'b1;
    m_prev = w;
    for (int i = 0; i < 8; i++) begin
      if (w[2*i+1] != w[2*i]) bits_q.push_back(w[2*i+1]);
    end
    while (bits_q.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b[i] = bits_q.pop_front();
      exp_q.push_back(b);
    end
  endtask

  // Monitor: sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_frz = 1'b0;
        first_h  = 1'b1;
      end else begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            chk("head_byte", 32'(out_data), 32'(exp_q[0]));
            if (out_ready) begin
              void'(exp_q.pop_front());
            end
          end
          if (out_ready) begin
            pop_cnt++;
            last_pop = out_data;
          end
        end
        if (rnd_freeze && !prev_frz) begin
          if (!first_h) chk("low_len_ge_run", 32'(lo_len >= RUN), 32'd1);
          first_h = 1'b0;
          chk("addr_at_freeze", 32'(rnd_addr), 32'(m_addr));
          chk("fault_at_harvest", 32'(fault), 32'(m_fault));
          model_harvest(rnd_word);
          hcount++;
          hi_len = 1;
        end else if (rnd_freeze) begin
          hi_len++;
        end
        if (!rnd_freeze && prev_frz) begin
          chk("freeze_high_len", 32'(hi_len), 32'(SETTLE + 8));
          m_addr = (m_addr + 1) % NB;
          chk("addr_on_release", 32'(rnd_addr), 32'(m_addr));
          lo_len = 1;
        end else if (!rnd_freeze) begin
          lo_len++;
        end
        prev_frz = rnd_freeze;
      end
    end
  end

  // Random source word / consumer ready driver, away from both clock edges
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst && !rnd_freeze) begin
        if (mode == 1)      rnd_word = 16'($urandom);
        else if (mode == 2) rnd_word = hcount[0] ? 16'h4321 : 16'h1234;
      end
      if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1);
    en  = 1'b0;
    rst = 1'b1;
    model_reset();
    step(3);
    rst = 1'b0;
  endtask

  task automatic wait_harvests(input int n);
    int target;
    int budget;
    target = hcount + n;
    budget = n * 80 + 50;
    while (hcount < target && budget > 0) begin
      step(1);
      budget--;
    end
    chk("harvest_timeout", 32'(hcount >= target), 32'd1);
  endtask

  task automatic wait_idle();
    step(60);
  endtask

  task automatic run_fixed(input logic [15:0] w, input int n, input int nbytes, input logic [7:0] b);
    int p0;
    mode      = 0;
    rnd_word  = w;
    out_ready = 1'b1;
    p0        = pop_cnt;
    en        = 1'b1;
    wait_harvests(n);
    en = 1'b0;
    wait_idle();
    chk("fixed_nbytes", 32'(pop_cnt - p0), 32'(nbytes));
    if (nbytes > 0) chk("fixed_byte", 32'(last_pop), 32'(b));
    chk("fixed_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int h0;
    int p0;
    n_chk = 0; n_err = 0; hcount = 0; pop_cnt = 0; last_pop = 8'h00;
    mode = 0; rdy_mode = 0;
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; rnd_word = 16'h0000;
    model_reset();
    step(3);
    rst = 1'b0;
    step(2);
    chk("rst_freeze", 32'(rnd_freeze), 32'd0);
    chk("rst_addr",   32'(rnd_addr),   32'd0);
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_data",   32'(out_data),   32'd0);
    chk("rst_fault",  32'(fault),      32'd0);

    // Directed debias patterns
    run_fixed(16'hAAAA, 3, 3, 8'hFF);
    run_fixed(16'h9999, 2, 2, 8'hAA);
    run_fixed(16'h5555, 2, 2, 8'h00);
    run_fixed(16'h0009, 4, 1, 8'hAA);

    // Random words, random ready, full address scan
    do_reset();
    mode = 1; rdy_mode = 1; en = 1'b1;
    wait_harvests(33);
    en = 1'b0;
    step(1);
    mode = 0; rdy_mode = 0; out_ready = 1'b1;
    wait_idle();
    chk("scan_addr_end", 32'(rnd_addr), 32'd1);
    chk("scan_drained",  32'(exp_q.size()), 32'd0);

    // Backpressure: FIFO fills, FSM parks
    out_ready = 1'b0; rnd_word = 16'hAAAA; h0 = hcount; en = 1'b1;
    step(400);
    chk("bp_harvests", 32'(hcount - h0), 32'd4);
    chk("bp_buffered", 32'(exp_q.size()), 32'd4);
    chk("bp_freeze",   32'(rnd_freeze), 32'd0);
    chk("bp_valid",    32'(out_valid), 32'd1);
    p0 = pop_cnt;
    out_ready = 1'b1;
    wait_harvests(2);
    en = 1'b0;
    wait_idle();
    chk("bp_drain_cnt", 32'(pop_cnt - p0 >= 6), 32'd1);
    chk("bp_drained",   32'(exp_q.size()), 32'd0);

    // Health check: all-zero source
    do_reset();
    p0 = pop_cnt;
    run_fixed(16'h0000, 8, 0, 8'h00);
    chk("stuck_fault", 32'(fault), 32'd1);
    run_fixed(16'hAAAA, 2, 2, 8'hFF);
    chk("fault_sticky", 32'(fault), 32'd1);
    do_reset();
    chk("fault_cleared", 32'(fault), 32'd0);
    rnd_word = hcount[0] ? 16'h4321 : 16'h1234;
    mode = 2; out_ready = 1'b1; en = 1'b1;
    wait_harvests(10);
    en = 1'b0;
    wait_idle();
    mode = 0;
    chk("alt_no_fault", 32'(fault), 32'd0);
    chk("alt_drained",  32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of EXTRACT with bytes buffered
    do_reset();
    rnd_word = 16'hAAAA; out_ready = 1'b0; en = 1'b1;
    wait_harvests(2);
    wait_harvests(1);
    step(5);
    chk("pre_rst_valid",  32'(out_valid), 32'd1);
    chk("pre_rst_freeze", 32'(rnd_freeze), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_freeze", 32'(rnd_freeze), 32'd0);
    chk("arst_addr",   32'(rnd_addr),   32'd0);
    chk("arst_valid",  32'(out_valid),  32'd0);
    chk("arst_data",   32'(out_data),   32'd0);
    chk("arst_fault",  32'(fault),      32'd0);
    en = 1'b0;
    step(3);
    rst = 1'b0;
    step(4);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
